// File: rtl/tlul_mem_responder.sv
// TL-UL device adapter for a single-cycle SRAM: decodes A beats, strobes the
// memory, and returns D responses in acceptance order through a small FIFO.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// Handshakes: a beat moves on A when a_valid && a_ready and on D when
// d_valid && d_ready; a_ready depends only on registered occupancy.
module tlul_mem_responder
  import tlul_pkg::*;
#(
  parameter int unsigned MemAw     = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          READ_ONLY = 1'b0,
  parameter int unsigned RspDepth  = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  tl_h2d_t          tl_i,
  output tl_d2h_t          tl_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [MemAw-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic [3:0]       mem_wmask_o,
  input  logic [31:0]      mem_rdata_i
);

  localparam int unsigned PtrW = $clog2(RspDepth);
  localparam int unsigned CntW = $clog2(RspDepth + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(RspDepth);

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] size;
    logic [7:0] source;
    logic       error;
    logic       is_read;
  } pend_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic        error;
    logic [31:0] data;
  } rsp_t;

  pend_t           pend_q;
  logic            pend_valid_q;
  rsp_t            fifo_q [RspDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic [31:0]     offset;
  logic            op_get, op_put, op_ok, size_ok, align_ok, range_ok, is_err;
  logic [CntW-1:0] occupancy;
  logic            a_ready, accept, d_valid, push, pop;
  rsp_t            push_entry, head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Request decode; the upper-bound test is "no offset bits above the window".
  assign offset   = tl_i.a_address - BASE_ADDR;
  assign op_get   = (tl_i.a_opcode == Get);
  assign op_put   = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign op_ok    = op_get || op_put;
  assign size_ok  = (tl_i.a_size != 2'd3);
  assign range_ok = (tl_i.a_address >= BASE_ADDR) && ((offset >> (MemAw + 2)) == '0);
  assign is_err   = !op_ok || !size_ok || !align_ok || !range_ok || (READ_ONLY && op_put);

  always_comb begin
    align_ok = 1'b0;
    case (tl_i.a_size)
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = ~tl_i.a_address[0];
      2'd2:    align_ok = (tl_i.a_address[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
  end

  assign occupancy = count_q + CntW'(pend_valid_q);
  assign a_ready   = rst_ni && (occupancy < DepthC);
  assign accept    = tl_i.a_valid && a_ready;
  assign d_valid   = rst_ni && (count_q != '0);
  assign push      = pend_valid_q;
  assign pop       = d_valid && tl_i.d_ready;

  assign mem_req_o   = accept && !is_err;
  assign mem_we_o    = op_put;
  assign mem_addr_o  = offset[MemAw+1:2];
  assign mem_wdata_o = tl_i.a_data;
  assign mem_wmask_o = tl_i.a_mask;

  // Read data arrives the cycle after the strobe, which is when pend drains.
  assign push_entry = '{
    opcode: pend_q.opcode,
    size:   pend_q.size,
    source: pend_q.source,
    error:  pend_q.error,
    data:   (pend_q.is_read && !pend_q.error) ? mem_rdata_i : 32'h0
  };
  assign head = fifo_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      pend_valid_q <= accept;
      if (accept) begin
        pend_q <= '{
          opcode:  op_get ? AccessAckData : AccessAck,
          size:    tl_i.a_size,
          source:  tl_i.a_source,
          error:   is_err,
          is_read: op_get
        };
      end
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = a_ready;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = head.opcode;
    tl_o.d_size   = head.size;
    tl_o.d_source = head.source;
    tl_o.d_data   = head.data;
    tl_o.d_error  = head.error;
  end

  // Integrity and param fields are carried but deliberately not inspected.
  logic unused_a;
  assign unused_a = ^{tl_i.a_param, tl_i.a_user};

endmodule

// File: tb/tb_tlul_mem_responder.sv
// Bench for tlul_mem_responder: directed scenarios plus random traffic checked
// against a transaction-level model of memory contents and response order.
module tb_tlul_mem_responder;
  import tlul_pkg::*;

  localparam int          MAW   = 8;
  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int          DEPTH = 2;
  localparam int          WORDS = 1 << MAW;
  localparam logic [31:0] WIN   = 32'(4 * WORDS);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tl_h2d_t          tl_i, tl_ro_i;
  tl_d2h_t          tl_o, tl_ro_o;
  logic             mem_req, mem_we, ro_req, ro_we;
  logic [MAW-1:0]   mem_addr, ro_addr;
  logic [31:0]      mem_wdata, mem_rdata, ro_wdata;
  logic [3:0]       mem_wmask, ro_wmask;
  logic [31:0]      ro_rdata = 32'hA5A5_A5A5;

  tlul_mem_responder #(.MemAw(MAW), .BASE_ADDR(BASE), .READ_ONLY(1'b0), .RspDepth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i), .tl_o(tl_o),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata)
  );

  tlul_mem_responder #(.MemAw(MAW), .BASE_ADDR(BASE), .READ_ONLY(1'b1), .RspDepth(DEPTH)) dut_ro (
    .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_ro_i), .tl_o(tl_ro_o),
    .mem_req_o(ro_req), .mem_we_o(ro_we), .mem_addr_o(ro_addr),
    .mem_wdata_o(ro_wdata), .mem_wmask_o(ro_wmask), .mem_rdata_i(ro_rdata)
  );

  function automatic logic [31:0] init_word(input int w);
    return (w == 4) ? 32'hDEAD_BEEF : (32'(w) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Single-cycle memory attached to the main instance.
  logic [31:0] mem_arr [WORDS];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int w = 0; w < WORDS; w++) mem_arr[w] <= init_word(w);
      mem_ready <= 1'b1;
    end else if (mem_req) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem_arr[mem_addr];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [WORDS];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [2:0] op, input logic [1:0] size,
                                   input logic [31:0] addr, input bit ro);
    longint a = 64'(addr);
    bit is_put = (op == 3'd0) || (op == 3'd1);
    if (!(is_put || op == 3'd4)) return 1'b1;
    if (size > 2'd2) return 1'b1;
    if ((addr % (32'd1 << size)) != 0) return 1'b1;
    if (a < 64'(BASE) || a >= 64'(BASE) + 64'(WIN)) return 1'b1;
    if (ro && is_put) return 1'b1;
    return 1'b0;
  endfunction

  // Compare one cycle of DUT behaviour against the model, then update it.
  task automatic check_cycle();
    bit   exp_dv, acc, err, is_put;
    int   idx;
    exp_t e;
    chk("a_ready", 32'(tl_o.a_ready), 32'(exp_q.size() < DEPTH));
    exp_dv = 1'b0;
    if (exp_q.size() > 0) exp_dv = (exp_q[0].cyc + 2 <= cyc);
    chk("d_valid", 32'(tl_o.d_valid), 32'(exp_dv));
    if (tl_o.d_valid && exp_dv) begin
      chk("d_opcode", 32'(tl_o.d_opcode), 32'(exp_q[0].op));
      chk("d_size",   32'(tl_o.d_size),   32'(exp_q[0].size));
      chk("d_source", 32'(tl_o.d_source), 32'(exp_q[0].src));
      chk("d_data",   tl_o.d_data,        exp_q[0].data);
      chk("d_error",  32'(tl_o.d_error),  32'(exp_q[0].err));
      chk("d_param_sink_user", 32'({tl_o.d_param, tl_o.d_sink, tl_o.d_user}), 32'h0);
    end
    acc = tl_i.a_valid && tl_o.a_ready;
    if (acc) begin
      err    = model_err(tl_i.a_opcode, tl_i.a_size, tl_i.a_address, 1'b0);
      is_put = (tl_i.a_opcode == 3'd0) || (tl_i.a_opcode == 3'd1);
      idx    = 0;
      chk("mem_req", 32'(mem_req), 32'(!err));
      if (!err) begin
        idx = int'((tl_i.a_address - BASE) >> 2);
        chk("mem_we",   32'(mem_we),   32'(is_put));
        chk("mem_addr", 32'(mem_addr), 32'(idx));
        if (is_put) begin
          chk("mem_wdata", mem_wdata, tl_i.a_data);
          chk("mem_wmask", 32'(mem_wmask), 32'(tl_i.a_mask));
          for (int b = 0; b < 4; b++)
            if (tl_i.a_mask[b]) model_mem[idx][8*b +: 8] = tl_i.a_data[8*b +: 8];
        end
      end
      e.op   = (tl_i.a_opcode == 3'd4) ? 3'd1 : 3'd0;
      e.size = tl_i.a_size;
      e.src  = tl_i.a_source;
      e.err  = err;
      e.data = (!err && !is_put) ? model_mem[idx] : 32'h0;
      e.cyc  = cyc;
    end else begin
      chk("mem_req_idle", 32'(mem_req), 32'h0);
    end
    if (tl_o.d_valid && tl_i.d_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic set_a(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    tl_i.a_opcode  = op;
    tl_i.a_size    = size;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    tl_i.a_source  = src;
    tl_i.a_valid   = 1'b1;
  endtask

  task automatic directed(input string tag, input logic [2:0] op, input logic [1:0] size,
                          input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                          input logic [7:0] src, input bit exp_req, input logic [MAW-1:0] exp_maddr,
                          input logic [2:0] exp_dop, input bit exp_derr, input logic [31:0] exp_ddata);
    set_a(op, size, addr, mask, data, src);
    @(negedge clk);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'(exp_req));
    if (exp_req) begin
      chk({tag, "_mem_addr"},  32'(mem_addr),  32'(exp_maddr));
      chk({tag, "_mem_we"},    32'(mem_we),    32'(op != 3'd4));
      chk({tag, "_mem_wmask"}, 32'(mem_wmask), 32'(mask));
    end
    check_cycle();
    advance();
    tl_i.a_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_no_early_d"}, 32'(tl_o.d_valid), 32'h0);
    check_cycle();
    advance();
    @(negedge clk);
    chk({tag, "_d_valid"},  32'(tl_o.d_valid),  32'h1);
    chk({tag, "_d_opcode"}, 32'(tl_o.d_opcode), 32'(exp_dop));
    chk({tag, "_d_error"},  32'(tl_o.d_error),  32'(exp_derr));
    chk({tag, "_d_data"},   tl_o.d_data,        exp_ddata);
    chk({tag, "_d_source"}, 32'(tl_o.d_source), 32'(src));
    check_cycle();
    advance();
  endtask

  task automatic randomize_a();
    int          k;
    logic [2:0]  op;
    logic [31:0] off;
    k = $urandom_range(0, 19);
    if (k < 8)       op = 3'd4;
    else if (k < 13) op = 3'd0;
    else if (k < 17) op = 3'd1;
    else begin
      op = 3'($urandom_range(2, 7));
      if (op == 3'd4) op = 3'd5;
    end
    tl_i.a_opcode = op;
    tl_i.a_size   = ($urandom_range(0, 9) < 7) ? 2'd2 : 2'($urandom_range(0, 3));
    k = $urandom_range(0, 19);
    if (k == 0)      tl_i.a_address = BASE - 32'(4 * $urandom_range(1, 4));
    else if (k == 1) tl_i.a_address = BASE + WIN + 32'(4 * $urandom_range(0, 3));
    else begin
      off = 32'($urandom_range(0, int'(WIN) - 1));
      if ($urandom_range(0, 4) != 0) off = off & 32'hFFFF_FFFC;
      tl_i.a_address = BASE + off;
    end
    tl_i.a_mask   = 4'($urandom_range(0, 15));
    tl_i.a_data   = $urandom;
    tl_i.a_source = 8'($urandom_range(0, 255));
    tl_i.a_param  = 3'($urandom_range(0, 7));
    tl_i.a_user   = 18'($urandom);
    tl_i.a_valid  = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int  n_acc;
    bit  got;
    tl_i    = '0;
    tl_ro_i = '0;
    for (int w = 0; w < WORDS; w++) model_mem[w] = init_word(w);

    // Reset with a beat presented: nothing may be accepted or strobed.
    set_a(3'd4, 2'd2, BASE, 4'hF, 32'h0, 8'h01);
    tl_i.d_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_a_ready", 32'(tl_o.a_ready), 32'h0);
      chk("rst_d_valid", 32'(tl_o.d_valid), 32'h0);
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      advance();
    end
    tl_i.a_valid = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    chk("post_rst_a_ready", 32'(tl_o.a_ready), 32'h1);
    check_cycle();
    advance();

    directed("get_dead", 3'd4, 2'd2, BASE + 32'h10, 4'hF, 32'h0, 8'h05,
             1'b1, MAW'(4), 3'd1, 1'b0, 32'hDEAD_BEEF);
    directed("put_partial", 3'd1, 2'd2, BASE + 32'h8, 4'b0011, 32'h1234, 8'h11,
             1'b1, MAW'(2), 3'd0, 1'b0, 32'h0);
    directed("get_oob", 3'd4, 2'd2, BASE + WIN, 4'hF, 32'h0, 8'h21,
             1'b0, MAW'(0), 3'd1, 1'b1, 32'h0);
    directed("get_misalign", 3'd4, 2'd2, BASE + 32'h2, 4'hF, 32'h0, 8'h22,
             1'b0, MAW'(0), 3'd1, 1'b1, 32'h0);
    directed("bad_opcode", 3'd3, 2'd2, BASE, 4'hF, 32'h0, 8'h23,
             1'b0, MAW'(0), 3'd0, 1'b1, 32'h0);

    // Backpressure: only DEPTH beats fit while D is stalled.
    tl_i.d_ready = 1'b0;
    set_a(3'd4, 2'd2, BASE + 32'h20, 4'hF, 32'h0, 8'h31);
    n_acc = 0;
    for (int t = 0; t < 6; t++) begin
      sample();
      got = tl_i.a_valid && tl_o.a_ready;
      advance();
      if (got) begin
        n_acc++;
        tl_i.a_address = tl_i.a_address + 32'h4;
        tl_i.a_source  = tl_i.a_source + 8'h1;
      end
    end
    chk("bp_accepted", 32'(n_acc), 32'(DEPTH));
    repeat (2) begin
      @(negedge clk);
      chk("bp_a_ready", 32'(tl_o.a_ready), 32'h0);
      chk("bp_head_src", 32'(tl_o.d_source), 32'h31);
      check_cycle();
      advance();
    end
    tl_i.d_ready = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      sample();
      got = tl_i.a_valid && tl_o.a_ready;
      advance();
    end
    chk("bp_third_accept", 32'(got), 32'h1);
    tl_i.a_valid = 1'b0;
    repeat (6) step();

    // Read-only instance rejects writes without touching memory.
    tl_ro_i.a_opcode  = 3'd0;
    tl_ro_i.a_size    = 2'd2;
    tl_ro_i.a_address = BASE + 32'h40;
    tl_ro_i.a_mask    = 4'hF;
    tl_ro_i.a_data    = 32'h55;
    tl_ro_i.a_source  = 8'h07;
    tl_ro_i.d_ready   = 1'b1;
    tl_ro_i.a_valid   = 1'b1;
    @(negedge clk);
    chk("ro_a_ready", 32'(tl_ro_o.a_ready), 32'h1);
    chk("ro_mem_req", 32'(ro_req), 32'h0);
    advance();
    tl_ro_i.a_valid = 1'b0;
    @(negedge clk);
    chk("ro_no_early_d", 32'(tl_ro_o.d_valid), 32'h0);
    advance();
    @(negedge clk);
    chk("ro_d_valid",  32'(tl_ro_o.d_valid),  32'h1);
    chk("ro_d_opcode", 32'(tl_ro_o.d_opcode), 32'h0);
    chk("ro_d_error",  32'(tl_ro_o.d_error),  32'h1);
    chk("ro_d_data",   tl_ro_o.d_data,        32'h0);
    chk("ro_d_source", 32'(tl_ro_o.d_source), 32'h7);
    advance();
    @(negedge clk);
    chk("ro_d_drained", 32'(tl_ro_o.d_valid), 32'h0);
    advance();

    // Reset mid-operation with queued responses: they must vanish.
    tl_i.d_ready = 1'b0;
    set_a(3'd4, 2'd2, BASE + 32'h30, 4'hF, 32'h0, 8'h41);
    n_acc = 0;
    for (int t = 0; t < 6 && n_acc < 2; t++) begin
      sample();
      got = tl_i.a_valid && tl_o.a_ready;
      advance();
      if (got) begin
        n_acc++;
        tl_i.a_address = tl_i.a_address + 32'h4;
      end
    end
    chk("mid_rst_queued", 32'(n_acc), 32'h2);
    tl_i.a_valid = 1'b0;
    repeat (2) step();
    set_a(3'd4, 2'd2, BASE + 32'h38, 4'hF, 32'h0, 8'h43);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_a_ready", 32'(tl_o.a_ready), 32'h0);
      chk("mid_rst_d_valid", 32'(tl_o.d_valid), 32'h0);
      chk("mid_rst_mem_req", 32'(mem_req), 32'h0);
      advance();
    end
    exp_q.delete();
    tl_i.a_valid = 1'b0;
    tl_i.d_ready = 1'b1;
    rst_n        = 1'b1;
    @(negedge clk);
    chk("mid_rst_release_a_ready", 32'(tl_o.a_ready), 32'h1);
    chk("mid_rst_release_d_valid", 32'(tl_o.d_valid), 32'h0);
    check_cycle();
    advance();
    repeat (4) step();

    // Random traffic with random D backpressure.
    for (int n = 0; n < 400; n++) begin
      if (!tl_i.a_valid && $urandom_range(0, 3) != 0) randomize_a();
      tl_i.d_ready = ($urandom_range(0, 3) != 0);
      sample();
      got = tl_i.a_valid && tl_o.a_ready;
      advance();
      if (got) tl_i.a_valid = 1'b0;
    end
    tl_i.a_valid = 1'b0;
    tl_i.d_ready = 1'b1;
    repeat (8) step();
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
